// File: rtl/fod_fcw_seq_if.sv
// Request/acknowledge bus of the FCW sequencer.
// The master issues new-FCW requests; the slave (sequencer) returns ACK/ERR pulses.
interface fod_fcw_seq_if #(
    parameter int unsigned WI = 6,
    parameter int unsigned WF = 16
);
    logic              req;
    logic [WI+WF-1:0]  fcw_req;
    logic              ack;
    logic              err;

    modport master (
        output req,
        output fcw_req,
        input  ack,
        input  err
    );

    modport slave (
        input  req,
        input  fcw_req,
        output ack,
        output err
    );
endinterface

// File: rtl/fod_fcw_seq.sv
// FOD FCW sequencer: accepts range-checked FCW requests, freezes the DSM, ramps FCW,
// lets the MMD/DSM settle, then re-runs phase-sync calibration and reports lock.
module fod_fcw_seq #(
    parameter int unsigned WI         = 6,
    parameter int unsigned WF         = 16,
    parameter int unsigned FCW_RST    = 309329,
    parameter int unsigned INT_MIN    = 4,
    parameter int unsigned INT_MAX    = 62,
    parameter int unsigned RAMP_STEP  = 4096,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned LOCK_TO    = 1023
) (
    input  logic               clk,
    input  logic               rst,
    fod_fcw_seq_if.slave       bus,
    output logic [WI+WF-1:0]   fcw_fod,
    output logic               dsm_en,
    output logic               cali_rst,
    input  logic               cali_lock,
    output logic               busy,
    output logic               locked,
    output logic [2:0]         state
);

    localparam int unsigned W       = WI + WF;
    localparam int unsigned W1      = W + 1;
    localparam int unsigned CNT_MAX = (SETTLE_CYC > LOCK_TO) ? SETTLE_CYC : LOCK_TO;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [W-1:0]  FCW_INIT    = W'(FCW_RST);
    localparam logic [W-1:0]  STEP_W      = W'(RAMP_STEP);
    localparam logic [W:0]    STEP_EXT    = W1'(RAMP_STEP);
    localparam logic [WI-1:0] IMIN        = WI'(INT_MIN);
    localparam logic [WI-1:0] IMAX        = WI'(INT_MAX);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TO - 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StFreeze   = 3'd1,
        StRamp     = 3'd2,
        StSettle   = 3'd3,
        StLockWait = 3'd4
    } st_e;

    st_e            st_q;
    logic [W-1:0]   target_q;
    logic [W-1:0]   fcw_q;
    logic [CW-1:0]  cnt_q;
    logic           ack_q;
    logic           err_q;
    logic           dsm_en_q;
    logic           cali_rst_q;
    logic           busy_q;
    logic           locked_q;

    logic signed [W:0] diff;
    logic [W:0]        diff_abs;
    logic              ramp_done;
    logic [WI-1:0]     req_int;
    logic              req_legal;

    // One extra bit keeps the target-minus-current difference signed without wrap.
    assign diff      = $signed({1'b0, target_q}) - $signed({1'b0, fcw_q});
    assign diff_abs  = diff[W] ? -diff : diff;
    assign ramp_done = (RAMP_STEP == 0) || (diff_abs <= STEP_EXT);

    assign req_int   = bus.fcw_req[W-1:WF];
    assign req_legal = (req_int >= IMIN) && (req_int <= IMAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q       <= StFreeze;
            target_q   <= FCW_INIT;
            fcw_q      <= FCW_INIT;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dsm_en_q   <= 1'b0;
            cali_rst_q <= 1'b1;
            busy_q     <= 1'b1;
            locked_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            unique case (st_q)
                StIdle: begin
                    // ACK still high means the requester has not yet seen it: skip one cycle.
                    if (bus.req && !ack_q) begin
                        ack_q <= 1'b1;
                        if (req_legal) begin
                            target_q <= bus.fcw_req;
                            st_q     <= StFreeze;
                            busy_q   <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StFreeze: begin
                    dsm_en_q   <= 1'b0;
                    cali_rst_q <= 1'b1;
                    locked_q   <= 1'b0;
                    st_q       <= StRamp;
                end
                StRamp: begin
                    if (ramp_done) begin
                        fcw_q    <= target_q;
                        dsm_en_q <= 1'b1;
                        cnt_q    <= '0;
                        st_q     <= StSettle;
                    end else if (diff[W]) begin
                        fcw_q <= fcw_q - STEP_W;
                    end else begin
                        fcw_q <= fcw_q + STEP_W;
                    end
                end
                StSettle: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q      <= '0;
                        cali_rst_q <= 1'b0;
                        st_q       <= StLockWait;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StLockWait: begin
                    // Lock is tested first so it wins over a same-cycle timeout.
                    if (cali_lock) begin
                        locked_q <= 1'b1;
                        busy_q   <= 1'b0;
                        st_q     <= StIdle;
                    end else if (cnt_q == LOCK_LAST) begin
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                        st_q   <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    st_q   <= StFreeze;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ack  = ack_q;
    assign bus.err  = err_q;
    assign fcw_fod  = fcw_q;
    assign dsm_en   = dsm_en_q;
    assign cali_rst = cali_rst_q;
    assign busy     = busy_q;
    assign locked   = locked_q;
    assign state    = st_q;

endmodule

// File: tb/tb_fod_fcw_seq.sv
// Directed, table-driven bench for the FOD FCW sequencer: requests, rejects,
// ramp trajectories, lock/timeout and an async restart with a held request.
module tb_fod_fcw_seq;

    localparam int unsigned FCW_RST = 309329;

    logic        clk;
    logic        rst;
    logic        cali_lock;
    logic [21:0] fcw_fod;
    logic        dsm_en;
    logic        cali_rst;
    logic        busy;
    logic        locked;
    logic [2:0]  state;

    fod_fcw_seq_if #(.WI(6), .WF(16)) bus_if ();

    fod_fcw_seq dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .fcw_fod   (fcw_fod),
        .dsm_en    (dsm_en),
        .cali_rst  (cali_rst),
        .cali_lock (cali_lock),
        .busy      (busy),
        .locked    (locked),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int ack_cnt = 0;
    int err_cnt = 0;
    logic [21:0] model_fcw;

    always @(negedge clk) begin
        if (bus_if.ack === 1'b1) ack_cnt++;
        if (bus_if.err === 1'b1) err_cnt++;
    end

    typedef struct {
        logic [21:0] fcw;
        bit          legal;
        int          ramp;
        int          lock_delay;  // <0: never lock, expect timeout
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered with the DUT in FREEZE; runs ramp, settle and lock/timeout back to IDLE.
    task automatic run_seq(input logic [21:0] target, input int exp_ramp, input int lock_delay);
        int  n;
        int  d;
        int  e0;
        bit  done;
        step();
        chk("ramp_entry_state", 32'(state), 32'd2);
        chk("ramp_dsm_off", 32'(dsm_en), 32'd0);
        chk("ramp_locked_clr", 32'(locked), 32'd0);
        chk("ramp_cali_rst", 32'(cali_rst), 32'd1);
        chk("ramp_busy", 32'(busy), 32'd1);
        chk("ack_single_pulse", 32'(bus_if.ack), 32'd0);
        n = 0;
        done = 1'b0;
        while (!done && n < 2000) begin
            d = int'(target) - int'(model_fcw);
            if (d > 4096) model_fcw = model_fcw + 22'd4096;
            else if (d < -4096) model_fcw = model_fcw - 22'd4096;
            else begin
                model_fcw = target;
                done = 1'b1;
            end
            step();
            n++;
            chk("ramp_fcw", 32'(fcw_fod), 32'(model_fcw));
            chk("ramp_state", 32'(state), done ? 32'd3 : 32'd2);
            chk("ramp_dsm_en", 32'(dsm_en), done ? 32'd1 : 32'd0);
        end
        chk("ramp_cycles", n, exp_ramp);
        repeat (15) step();
        chk("settle_state", 32'(state), 32'd3);
        chk("settle_cali_rst", 32'(cali_rst), 32'd1);
        step();
        chk("lockwait_entry", 32'(state), 32'd4);
        chk("lockwait_cali_rst", 32'(cali_rst), 32'd0);
        e0 = err_cnt;
        if (lock_delay >= 0) begin
            repeat (lock_delay) step();
            cali_lock = 1'b1;
            step();
            cali_lock = 1'b0;
            chk("lock_state", 32'(state), 32'd0);
            chk("lock_locked", 32'(locked), 32'd1);
            chk("lock_busy", 32'(busy), 32'd0);
            chk("lock_no_err", err_cnt, e0);
        end else begin
            n = 0;
            while (bus_if.err !== 1'b1 && n < 2000) begin
                step();
                n++;
            end
            chk("timeout_cycles", n, 1023);
            chk("timeout_state", 32'(state), 32'd0);
            chk("timeout_locked", 32'(locked), 32'd0);
            chk("timeout_busy", 32'(busy), 32'd0);
            chk("timeout_dsm_kept", 32'(dsm_en), 32'd1);
            chk("timeout_fcw_kept", 32'(fcw_fod), 32'(target));
            step();
            chk("timeout_err_pulse", 32'(bus_if.err), 32'd0);
        end
    endtask

    task automatic do_request(input vec_t v);
        bus_if.req     = 1'b1;
        bus_if.fcw_req = v.fcw;
        step();
        chk("req_ack", 32'(bus_if.ack), 32'd1);
        chk("req_err", 32'(bus_if.err), v.legal ? 32'd0 : 32'd1);
        chk("req_state", 32'(state), v.legal ? 32'd1 : 32'd0);
        chk("req_fcw_hold", 32'(fcw_fod), 32'(model_fcw));
        bus_if.req = 1'b0;
        if (v.legal) begin
            run_seq(v.fcw, v.ramp, v.lock_delay);
        end else begin
            step();
            chk("rej_ack_clr", 32'(bus_if.ack), 32'd0);
            chk("rej_err_clr", 32'(bus_if.err), 32'd0);
            chk("rej_state", 32'(state), 32'd0);
            chk("rej_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int a0;
        int n;
        vecs[0] = '{fcw: 22'd327680,  legal: 1'b1, ramp: 5,   lock_delay: 3};
        vecs[1] = '{fcw: 22'd229376,  legal: 1'b0, ramp: 0,   lock_delay: 0};
        vecs[2] = '{fcw: 22'd4128768, legal: 1'b0, ramp: 0,   lock_delay: 0};
        vecs[3] = '{fcw: 22'd262143,  legal: 1'b0, ramp: 0,   lock_delay: 0};
        vecs[4] = '{fcw: 22'd262144,  legal: 1'b1, ramp: 16,  lock_delay: 3};
        vecs[5] = '{fcw: 22'd262144,  legal: 1'b1, ramp: 1,   lock_delay: 0};
        vecs[6] = '{fcw: 22'd4128767, legal: 1'b1, ramp: 944, lock_delay: 3};
        vecs[7] = '{fcw: 22'd309329,  legal: 1'b1, ramp: 933, lock_delay: 3};
        vecs[8] = '{fcw: 22'd327680,  legal: 1'b1, ramp: 5,   lock_delay: -1};
        vecs[9] = '{fcw: 22'd262144,  legal: 1'b1, ramp: 16,  lock_delay: 1022};

        rst            = 1'b1;
        cali_lock      = 1'b0;
        bus_if.req     = 1'b0;
        bus_if.fcw_req = '0;
        model_fcw      = 22'(FCW_RST);
        repeat (2) step();
        chk("rst_state", 32'(state), 32'd1);
        chk("rst_fcw", 32'(fcw_fod), FCW_RST);
        chk("rst_dsm_en", 32'(dsm_en), 32'd0);
        chk("rst_cali_rst", 32'(cali_rst), 32'd1);
        chk("rst_ack", 32'(bus_if.ack), 32'd0);
        chk("rst_err", 32'(bus_if.err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_locked", 32'(locked), 32'd0);

        // Bring-up: lock arrives 5 cycles after calibration reset is released.
        rst = 1'b0;
        run_seq(22'(FCW_RST), 1, 5);
        chk("bringup_no_ack", ack_cnt, 0);

        for (int i = 0; i < 10; i++) do_request(vecs[i]);

        // Held request from mid-ramp, then async reset during SETTLE.
        bus_if.req     = 1'b1;
        bus_if.fcw_req = 22'd327680;
        step();
        chk("hold_first_ack", 32'(bus_if.ack), 32'd1);
        bus_if.req = 1'b0;
        step();
        a0 = ack_cnt;
        repeat (3) step();
        bus_if.req     = 1'b1;
        bus_if.fcw_req = 22'd4128767;
        n = 0;
        while (state !== 3'd3 && n < 100) begin
            step();
            n++;
        end
        chk("hold_reached_settle", 32'(state), 32'd3);
        repeat (4) step();
        chk("hold_busy", 32'(busy), 32'd1);
        chk("hold_no_ack_busy", ack_cnt, a0);
        rst = 1'b1;
        #1;
        chk("arst_state", 32'(state), 32'd1);
        chk("arst_fcw", 32'(fcw_fod), FCW_RST);
        chk("arst_dsm_en", 32'(dsm_en), 32'd0);
        chk("arst_cali_rst", 32'(cali_rst), 32'd1);
        chk("arst_busy", 32'(busy), 32'd1);
        model_fcw = 22'(FCW_RST);
        #1;
        rst = 1'b0;
        run_seq(22'(FCW_RST), 1, 5);
        chk("arst_bringup_no_ack", ack_cnt, a0);
        step();
        chk("held_req_ack", 32'(bus_if.ack), 32'd1);
        chk("held_req_state", 32'(state), 32'd1);
        bus_if.req = 1'b0;
        run_seq(22'd4128767, 933, 3);
        chk("held_req_one_ack", ack_cnt, a0 + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
